// File: rtl/priority_encoder_scan.sv
// Latches an N-bit request vector and serialises the index of every set bit, one per
// y_valid/y_ready handshake, highest- or lowest-index first.
module priority_encoder_scan #(
  parameter int unsigned N         = 8,
  parameter int unsigned W         = $clog2(N),
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         d_valid,
  output logic         d_ready,
  output logic [W-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         y_last,
  output logic         none,
  output logic         busy
);

  if (N < 2 || N > 64) begin : g_bad_n
    $error("priority_encoder_scan: N must lie in 2..64");
  end
  if (W != $clog2(N)) begin : g_bad_w
    $error("priority_encoder_scan: W must equal $clog2(N)");
  end

  typedef enum logic {StIdle, StScan} state_e;

  state_e         state_q;
  logic [N-1:0]   pend_q;
  logic           none_q;
  logic [W-1:0]   idx;
  logic [N-1:0]   sel;
  logic           last;

  // The later hit in scan order wins, so the loop direction sets the priority.
  always_comb begin
    idx = '0;
    sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (pend_q[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend_q[i]) idx = W'(i);
      end
    end
    sel[idx] = 1'b1;
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign last = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          none_q <= d_valid && (d == '0);
          if (d_valid && (d != '0)) begin
            pend_q  <= d;
            state_q <= StScan;
          end
        end
        StScan: begin
          none_q <= 1'b0;
          if (y_ready) begin
            pend_q <= pend_q & ~sel;
            if (last) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign d_ready = (state_q == StIdle);
  assign busy    = (state_q == StScan);
  assign y_valid = busy;
  assign y       = idx;
  assign y_last  = last;
  assign none    = none_q;

endmodule

// File: tb/tb_priority_encoder_scan.sv
// Drives four encoder variants (8/MSB, 8/LSB, 4/MSB, 5/LSB) from shared stimulus and
// checks every output each cycle against a set-based model of the pending requests.
module tb_priority_encoder_scan;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] d;
  logic        d_valid;
  logic        y_ready;

  logic [5:0]  y_a     [NI];
  logic        yv_a    [NI];
  logic        dr_a    [NI];
  logic        yl_a    [NI];
  logic        none_a  [NI];
  logic        busy_a  [NI];

  int vectors    = 0;
  int miscompares = 0;

  logic [63:0] pm [NI];
  logic        nm [NI];

  always #5 clk = ~clk;

  function automatic int nsel(int g);
    return (g == 2) ? 4 : (g == 3) ? 5 : 8;
  endfunction

  function automatic bit msel(int g);
    return (g == 0) || (g == 2);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NG = (g == 2) ? 4 : (g == 3) ? 5 : 8;
    localparam bit          MG = (g == 0) || (g == 2);
    logic [$clog2(NG)-1:0] yw;
    priority_encoder_scan #(
      .N        (NG),
      .W        ($clog2(NG)),
      .MSB_FIRST(MG)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .d      (d[NG-1:0]),
      .d_valid(d_valid),
      .d_ready(dr_a[g]),
      .y      (yw),
      .y_valid(yv_a[g]),
      .y_ready(y_ready),
      .y_last (yl_a[g]),
      .none   (none_a[g]),
      .busy   (busy_a[g])
    );
    assign y_a[g] = 6'(yw);
  end

  // Next index to be emitted from a set of pending request numbers.
  function automatic int pick(logic [63:0] s, int n, bit msb);
    if (msb) begin
      for (int i = n - 1; i >= 0; i--) if (s[i]) return i;
    end else begin
      for (int i = 0; i < n; i++) if (s[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [63:0] wmask(int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic chk(input string nm_s, input int g, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t: got %0h, want %0h", nm_s, g, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      bit act_e = (pm[g] != 0);
      int ye    = act_e ? pick(pm[g], nsel(g), msel(g)) : 0;
      chk("y_valid", g, 64'(yv_a[g]), 64'(act_e));
      chk("busy",    g, 64'(busy_a[g]), 64'(act_e));
      chk("d_ready", g, 64'(dr_a[g]), 64'(!act_e));
      chk("y",       g, 64'(y_a[g]), 64'(ye));
      chk("y_last",  g, 64'(yl_a[g]), 64'($countones(pm[g]) == 1));
      chk("none",    g, 64'(none_a[g]), 64'(nm[g]));
    end
  endtask

  task automatic model_step();
    for (int g = 0; g < NI; g++) begin
      logic [63:0] dm = d & wmask(nsel(g));
      if (rst) begin
        pm[g] = '0;
        nm[g] = 1'b0;
      end else if (pm[g] == 0) begin
        nm[g] = d_valid && (dm == 0);
        if (d_valid && dm != 0) pm[g] = dm;
      end else begin
        nm[g] = 1'b0;
        if (y_ready) pm[g][pick(pm[g], nsel(g), msel(g))] = 1'b0;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic tick(input logic r, input logic dv, input logic [63:0] dd, input logic yr);
    rst     = r;
    d_valid = dv;
    d       = dd;
    y_ready = yr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int y8m [4];
    int y8l [4];
    int l8  [4];
    y8m = '{7, 5, 2, 0};
    y8l = '{0, 2, 5, 7};
    l8  = '{0, 0, 0, 1};
    for (int g = 0; g < NI; g++) begin
      pm[g] = '0;
      nm[g] = 1'b0;
    end

    tick(1, 0, 0, 0);
    tick(1, 1, 64'hFF, 1);
    chk("rst_y_valid", 0, 64'(yv_a[0]), 0);
    chk("rst_d_ready", 0, 64'(dr_a[0]), 1);
    chk("rst_y", 0, 64'(y_a[0]), 0);
    tick(0, 0, 0, 1);

    // 4-to-2 encoder table on the N=4 instance.
    for (int k = 0; k < 4; k++) begin
      tick(0, 1, 64'd1 << (3 - k), 1);
      chk("t1_y", 2, 64'(y_a[2]), 64'(3 - k));
      chk("t1_last", 2, 64'(yl_a[2]), 1);
      tick(0, 0, 0, 1);
      chk("t1_ready", 2, 64'(dr_a[2]), 1);
    end

    tick(0, 1, 64'hA5, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_y_msb", 0, 64'(y_a[0]), 64'(y8m[k]));
      chk("t2_last", 0, 64'(yl_a[0]), 64'(l8[k]));
      chk("t3_y_lsb", 1, 64'(y_a[1]), 64'(y8l[k]));
      tick(0, 0, 0, 1);
    end
    chk("t2_ready", 0, 64'(dr_a[0]), 1);

    tick(0, 1, 64'h18, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 64'hFF, 0);
      chk("t4_hold_y", 0, 64'(y_a[0]), 4);
      chk("t4_hold_v", 0, 64'(yv_a[0]), 1);
      chk("t4_d_ready", 0, 64'(dr_a[0]), 0);
    end
    tick(0, 0, 0, 1);
    chk("t4_y3", 0, 64'(y_a[0]), 3);
    chk("t4_last", 0, 64'(yl_a[0]), 1);
    tick(0, 0, 0, 1);
    chk("t4_ready", 0, 64'(dr_a[0]), 1);

    tick(0, 1, 0, 1);
    chk("t5_none", 0, 64'(none_a[0]), 1);
    chk("t5_y_valid", 0, 64'(yv_a[0]), 0);
    tick(0, 0, 0, 1);
    chk("t5_none_drop", 0, 64'(none_a[0]), 0);

    tick(0, 1, 64'hFF, 1);
    chk("t6_first", 0, 64'(y_a[0]), 7);
    tick(1, 0, 0, 1);
    chk("t6_y_valid", 0, 64'(yv_a[0]), 0);
    chk("t6_busy", 0, 64'(busy_a[0]), 0);
    tick(0, 1, 64'h01, 1);
    chk("t6_y", 0, 64'(y_a[0]), 0);
    chk("t6_last", 0, 64'(yl_a[0]), 1);
    tick(0, 0, 0, 1);
    chk("t6_ready", 0, 64'(dr_a[0]), 1);

    for (int k = 0; k < 2000; k++) begin
      logic [63:0] rd;
      rd = {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rd = '0;
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, rd,
           $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
